// File: rtl/minimig_cpu_pkg.sv
// -----------------------------------------------------------------------------
// minimig_cpu_pkg
// Definitions shared by the CPU-side interrupt receiver: vector numbers, the
// NMI priority level, the acknowledge FSM state encoding and a small helper
// that turns a priority level into its 68000 autovector number.
// -----------------------------------------------------------------------------
package minimig_cpu_pkg;

    // Autovectors 25..31 (0x19..0x1F) map to levels 1..7; 0x18 is "spurious".
    localparam logic [7:0] AUTOVEC_BASE = 8'h18;
    localparam logic [7:0] SPURIOUS_VEC = 8'h18;
    localparam logic [2:0] IPL_NMI      = 3'd7;

    typedef enum logic [1:0] {
        IACK_IDLE = 2'd0,
        IACK_WAIT = 2'd1,
        IACK_DONE = 2'd2
    } iack_state_e;

    function automatic logic [7:0] autovector(input logic [2:0] lvl);
        return AUTOVEC_BASE + {5'd0, lvl};
    endfunction

endpackage

// File: rtl/ipl_filter.sv
// -----------------------------------------------------------------------------
// ipl_filter
// Synchronises the active-low interrupt priority lines into the clk domain and
// filters them so that only a level seen on two consecutive clk7_en samples
// is forwarded.
//
// Ports:
//   clk         bus clock
//   _reset      asynchronous active-low reset
//   clk7_en     clock enable; the chain and filter only advance when high
//   _ipl        active-low priority level from the interrupt controller
//   stable_lvl  filtered, active-high priority level (0 = none)
// -----------------------------------------------------------------------------
module ipl_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk7_en,
    input  logic [2:0] _ipl,
    output logic [2:0] stable_lvl
);

    logic [2:0] raw_lvl;
    logic [2:0] next_lvl;
    logic [2:0] stable_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_q;
            logic [2:0] stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = _ipl;
            end else begin : g_next
                assign stage_in = g_sync[gi-1].stage_q;
            end
            // Released lines are high, so reset loads "no interrupt".
            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) begin
                    stage_q <= 3'b111;
                end else if (clk7_en) begin
                    stage_q <= stage_in;
                end
            end
        end

        // The two samples being compared are the one at the chain output and
        // the one directly behind it, so the filter adds a single tick of
        // latency. A one-deep chain has to look at the pin itself.
        if (SYNC_STAGES > 1) begin : g_look_chain
            assign next_lvl = ~g_sync[SYNC_STAGES-2].stage_q;
        end else begin : g_look_pin
            assign next_lvl = ~_ipl;
        end
    endgenerate

    assign raw_lvl = ~g_sync[SYNC_STAGES-1].stage_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            stable_q <= 3'd0;
        end else if (clk7_en && (raw_lvl == next_lvl)) begin
            stable_q <= raw_lvl;
        end
    end

    assign stable_lvl = stable_q;

endmodule

// File: rtl/cpu_ipl_receiver.sv
// -----------------------------------------------------------------------------
// cpu_ipl_receiver
// CPU-side end of the interrupt path: filters _ipl, detects the level-7 edge,
// compares against the SR mask, raises int_req/int_level and runs the
// interrupt-acknowledge handshake that returns an autovector or the spurious
// vector after ACK_DELAY clk7_en ticks.
//
// Ports:
//   clk, _reset, clk7_en    clock, async active-low reset, 7 MHz enable
//   _ipl[2:0]               active-low priority level (interrupt controller)
//   sr_mask[2:0]            SR interrupt mask from the core
//   iack_req, iack_level    start of an IACK cycle and the level acknowledged
//   int_req, int_level      registered interrupt request towards the core
//   iack_busy               acknowledge in progress
//   iack_done               one-tick pulse, vector/spurious valid
//   vector[7:0], spurious   returned vector number and its qualifier
// -----------------------------------------------------------------------------
module cpu_ipl_receiver
    import minimig_cpu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 3
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk7_en,
    input  logic [2:0] _ipl,
    input  logic [2:0] sr_mask,
    input  logic       iack_req,
    input  logic [2:0] iack_level,
    output logic       int_req,
    output logic [2:0] int_level,
    output logic       iack_busy,
    output logic       iack_done,
    output logic [7:0] vector,
    output logic       spurious
);

    localparam logic [3:0] ACK_LOAD = 4'(ACK_DELAY);

    logic [2:0]  stable_lvl;
    logic [2:0]  stable_prev_q;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_set, nmi_clr, match;
    logic        int_req_q, int_req_d;
    logic [2:0]  int_level_q, int_level_d;
    iack_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [7:0]  vector_q, vector_d;
    logic        spurious_q, spurious_d;

    ipl_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
        .clk        (clk),
        ._reset     (_reset),
        .clk7_en    (clk7_en),
        ._ipl       (_ipl),
        .stable_lvl (stable_lvl)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lvl_d      = lvl_q;
        vector_d   = vector_q;
        spurious_d = spurious_q;
        nmi_clr    = 1'b0;

        nmi_set = (stable_lvl == IPL_NMI) && (stable_prev_q != IPL_NMI);
        // Only consumed on the WAIT->DONE step, so a level that went away
        // while the core waited is reported as spurious.
        match   = ((lvl_q == IPL_NMI) && nmi_pend_q) ||
                  ((lvl_q == stable_lvl) && (lvl_q != 3'd0));

        case (state_q)
            IACK_IDLE: begin
                if (iack_req) begin
                    lvl_d   = iack_level;
                    cnt_d   = ACK_LOAD;
                    state_d = IACK_WAIT;
                end
            end
            IACK_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = IACK_DONE;
                    vector_d   = match ? autovector(lvl_q) : SPURIOUS_VEC;
                    spurious_d = ~match;
                    nmi_clr    = match && (lvl_q == IPL_NMI);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            IACK_DONE: state_d = IACK_IDLE;
            default:   state_d = IACK_IDLE;
        endcase

        // A fresh 0->7 edge on the same tick as the clear keeps the NMI alive.
        if (nmi_set) begin
            nmi_pend_d = 1'b1;
        end else if (nmi_clr) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end

        // A held level 7 requests only through nmi_pend, so it is excluded
        // from the mask compare; otherwise it would re-request forever.
        int_req_d   = 1'b0;
        int_level_d = 3'd0;
        if (nmi_pend_d) begin
            int_req_d   = 1'b1;
            int_level_d = IPL_NMI;
        end else if ((stable_lvl != IPL_NMI) && (stable_lvl > sr_mask)) begin
            int_req_d   = 1'b1;
            int_level_d = stable_lvl;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            stable_prev_q <= 3'd0;
            nmi_pend_q    <= 1'b0;
            int_req_q     <= 1'b0;
            int_level_q   <= 3'd0;
            state_q       <= IACK_IDLE;
            cnt_q         <= 4'd0;
            lvl_q         <= 3'd0;
            vector_q      <= 8'd0;
            spurious_q    <= 1'b0;
        end else if (clk7_en) begin
            stable_prev_q <= stable_lvl;
            nmi_pend_q    <= nmi_pend_d;
            int_req_q     <= int_req_d;
            int_level_q   <= int_level_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lvl_q         <= lvl_d;
            vector_q      <= vector_d;
            spurious_q    <= spurious_d;
        end
    end

    assign int_req   = int_req_q;
    assign int_level = int_level_q;
    assign iack_busy = (state_q != IACK_IDLE);
    assign iack_done = (state_q == IACK_DONE);
    assign vector    = vector_q;
    assign spurious  = spurious_q;

endmodule

// File: tb/tb_cpu_ipl_receiver.sv
module tb_cpu_ipl_receiver;

    localparam int SYNC = 2;
    localparam int DLY  = 3;

    logic       clk = 1'b0;
    logic       _reset;
    logic       clk7_en;
    logic [2:0] _ipl;
    logic [2:0] sr_mask;
    logic       iack_req;
    logic [2:0] iack_level;
    logic       int_req;
    logic [2:0] int_level;
    logic       iack_busy;
    logic       iack_done;
    logic [7:0] vector;
    logic       spurious;

    always #5 clk = ~clk;

    cpu_ipl_receiver #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY)) dut (
        .clk        (clk),
        ._reset     (_reset),
        .clk7_en    (clk7_en),
        ._ipl       (_ipl),
        .sr_mask    (sr_mask),
        .iack_req   (iack_req),
        .iack_level (iack_level),
        .int_req    (int_req),
        .int_level  (int_level),
        .iack_busy  (iack_busy),
        .iack_done  (iack_done),
        .vector     (vector),
        .spurious   (spurious)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, indexed by clk7_en tick number since reset release.
    int lvl_at  [0:8191];   // active-high level presented on each tick
    int stab_at [0:8191];   // filtered level after each tick
    int n;
    int m_nmi, m_int_req, m_int_lvl, m_busy, m_done, m_vec, m_sp;
    int lat_lvl, t_done;

    function automatic int lvl_s(int k);
        return (k >= 1) ? lvl_at[k] : 0;
    endfunction

    function automatic int stab(int k);
        return (k >= 1) ? stab_at[k] : 0;
    endfunction

    task automatic model_reset();
        n = 0; m_nmi = 0; m_int_req = 0; m_int_lvl = 0; m_busy = 0;
        m_done = 0; m_vec = 0; m_sp = 0; lat_lvl = 0; t_done = -100;
    endtask

    task automatic model_step();
        int s1, s2, a, b;
        bit set, clr, match;
        n++;
        lvl_at[n] = 7 - int'(_ipl);
        s1 = stab(n - 1);
        s2 = stab(n - 2);
        // A level becomes stable once two consecutive samples agree, after
        // passing through the synchroniser.
        a = lvl_s(n - SYNC);
        b = lvl_s(n - SYNC + 1);
        stab_at[n] = (a == b) ? a : s1;
        set = (s1 == 7) && (s2 != 7);
        clr = 0;
        if (n == t_done) begin
            match = (lat_lvl == 7 && m_nmi != 0) || (lat_lvl == s1 && lat_lvl != 0);
            m_vec = match ? 24 + lat_lvl : 24;
            m_sp  = match ? 0 : 1;
            clr   = match && lat_lvl == 7;
        end
        if (set) m_nmi = 1;
        else if (clr) m_nmi = 0;
        if (m_nmi != 0) begin
            m_int_req = 1; m_int_lvl = 7;
        end else if (s1 != 7 && s1 > int'(sr_mask)) begin
            m_int_req = 1; m_int_lvl = s1;
        end else begin
            m_int_req = 0; m_int_lvl = 0;
        end
        if (iack_req && n >= t_done + 2) begin
            lat_lvl = int'(iack_level);
            t_done  = n + DLY;
        end
        m_busy = (n <= t_done) ? 1 : 0;
        m_done = (n == t_done) ? 1 : 0;
    endtask

    task automatic check(string tag);
        total++;
        assert (int_req === 1'(m_int_req)) else begin
            bad++; $error("FAIL %s int_req got=%0b exp=%0d", tag, int_req, m_int_req);
        end
        total++;
        assert (int_level === 3'(m_int_lvl)) else begin
            bad++; $error("FAIL %s int_level got=%0d exp=%0d", tag, int_level, m_int_lvl);
        end
        total++;
        assert (iack_busy === 1'(m_busy)) else begin
            bad++; $error("FAIL %s iack_busy got=%0b exp=%0d", tag, iack_busy, m_busy);
        end
        total++;
        assert (iack_done === 1'(m_done)) else begin
            bad++; $error("FAIL %s iack_done got=%0b exp=%0d", tag, iack_done, m_done);
        end
        total++;
        assert (vector === 8'(m_vec)) else begin
            bad++; $error("FAIL %s vector got=%02h exp=%02h", tag, vector, m_vec);
        end
        total++;
        assert (spurious === 1'(m_sp)) else begin
            bad++; $error("FAIL %s spurious got=%0b exp=%0d", tag, spurious, m_sp);
        end
    endtask

    task automatic expect_val(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s got=%02h exp=%02h", tag, obs, exp);
        end
    endtask

    // One clk7_en tick, preceded by a random number of disabled clocks during
    // which nothing may move.
    task automatic tick(string tag);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            clk7_en = 1'b0;
            @(posedge clk); #1;
            check({tag, "/gap"});
        end
        clk7_en = 1'b1;
        model_step();
        @(posedge clk); #1;
        clk7_en = 1'b0;
        check(tag);
        if (m_done != 0)
            $display("iack tick=%0d level=%0d vector=%02h spurious=%0b", n, lat_lvl, vector, spurious);
    endtask

    task automatic ticks(string tag, int cnt);
        for (int i = 0; i < cnt; i++) tick(tag);
    endtask

    task automatic ack(string tag, logic [2:0] lvl);
        iack_req = 1'b1; iack_level = lvl;
        tick(tag);
        iack_req = 1'b0;
    endtask

    task automatic expect_all_zero(string tag);
        expect_val({tag, "/int_req"},   {7'd0, int_req},   8'd0);
        expect_val({tag, "/int_level"}, {5'd0, int_level}, 8'd0);
        expect_val({tag, "/busy"},      {7'd0, iack_busy}, 8'd0);
        expect_val({tag, "/done"},      {7'd0, iack_done}, 8'd0);
        expect_val({tag, "/vector"},    vector,            8'd0);
        expect_val({tag, "/spurious"},  {7'd0, spurious},  8'd0);
    endtask

    initial begin
        int dcount;
        int hold;

        _reset = 1'b0; clk7_en = 1'b0; _ipl = 3'b111; sr_mask = 3'd0;
        iack_req = 1'b0; iack_level = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_all_zero("reset");
        _reset = 1'b1;
        ticks("idle", 3);

        // 1: level 3 above mask 2, acknowledged with autovector 0x1B.
        _ipl = 3'b100; sr_mask = 3'd2;
        ticks("t1_lat", 3);
        expect_val("t1_req_early", {7'd0, int_req}, 8'd0);
        tick("t1_lat");
        expect_val("t1_req", {7'd0, int_req}, 8'd1);
        expect_val("t1_lvl", {5'd0, int_level}, 8'd3);
        ack("t1_ack", 3'd3);
        ticks("t1_wait", 2);
        expect_val("t1_done_early", {7'd0, iack_done}, 8'd0);
        tick("t1_wait");
        expect_val("t1_done", {7'd0, iack_done}, 8'd1);
        expect_val("t1_vec", vector, 8'h1B);
        expect_val("t1_spur", {7'd0, spurious}, 8'd0);
        _ipl = 3'b111;
        ticks("t1_rel", 6);

        // 2: level 2 at mask 2 stays quiet until the mask drops.
        _ipl = 3'b101; sr_mask = 3'd2;
        ticks("t2", 6);
        expect_val("t2_masked", {7'd0, int_req}, 8'd0);
        sr_mask = 3'd1;
        tick("t2_unmask");
        expect_val("t2_req", {7'd0, int_req}, 8'd1);
        expect_val("t2_lvl", {5'd0, int_level}, 8'd2);
        _ipl = 3'b111;
        ticks("t2_rel", 6);

        // 3: a single-tick glitch must never reach the filtered level.
        sr_mask = 3'd0;
        _ipl = 3'b010;
        tick("t3_glitch");
        _ipl = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick("t3");
            expect_val("t3_stable", {5'd0, dut.u_filter.stable_lvl}, 8'd0);
            expect_val("t3_req", {7'd0, int_req}, 8'd0);
        end

        // 4: NMI is edge-triggered and ignores a mask of 7.
        sr_mask = 3'd7; _ipl = 3'b000;
        ticks("t4", 4);
        expect_val("t4_req", {7'd0, int_req}, 8'd1);
        expect_val("t4_lvl", {5'd0, int_level}, 8'd7);
        ack("t4_ack", 3'd7);
        ticks("t4_wait", DLY);
        expect_val("t4_vec", vector, 8'h1F);
        expect_val("t4_clear", {7'd0, int_req}, 8'd0);
        ticks("t4_held", 5);
        expect_val("t4_held_req", {7'd0, int_req}, 8'd0);
        _ipl = 3'b111;
        ticks("t4_rel", 5);
        _ipl = 3'b000;
        ticks("t4_re", 4);
        expect_val("t4_rearm", {7'd0, int_req}, 8'd1);
        ack("t4_ack2", 3'd7);
        ticks("t4_wait2", DLY);
        _ipl = 3'b111;
        ticks("t4_rel2", 5);

        // 5: level drops while waiting -> spurious; a second request is ignored.
        sr_mask = 3'd0; _ipl = 3'b011;
        ticks("t5", 4);
        expect_val("t5_lvl", {5'd0, int_level}, 8'd4);
        _ipl = 3'b111;
        ack("t5_ack", 3'd4);
        ack("t5_ack_dup", 3'd4);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick("t5_wait");
            if (iack_done === 1'b1) begin
                dcount++;
                expect_val("t5_vec", vector, 8'h18);
                expect_val("t5_spur", {7'd0, spurious}, 8'd1);
            end
        end
        expect_val("t5_done_count", 8'(dcount), 8'd1);

        // 6: reset during WAIT aborts the acknowledge.
        _ipl = 3'b110;
        ticks("t6", 4);
        expect_val("t6_req", {7'd0, int_req}, 8'd1);
        ack("t6_ack", 3'd1);
        tick("t6_wait");
        #2;
        _reset = 1'b0;
        #1;
        expect_all_zero("t6_reset");
        model_reset();
        clk7_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clk7_en = 1'b0;
        check("t6_in_reset");
        _reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick("t6_after");
            if (iack_done === 1'b1) dcount++;
        end
        expect_val("t6_no_done", 8'(dcount), 8'd0);
        expect_val("t6_rereq", {7'd0, int_req}, 8'd1);

        // Random phase against the model.
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                _ipl = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 12));
            end
            hold--;
            if ($urandom_range(0, 9) == 0) sr_mask = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                iack_req   = 1'b1;
                iack_level = ($urandom_range(0, 1) == 1) ? 3'(m_int_lvl) : 3'($urandom_range(0, 7));
            end
            tick("rand");
            iack_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
